fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a prefetch buffer and presents {pc, instr} pairs to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap): flushes the buffer and discards stale in-flight responses.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- BUF_DEPTH, 4, prefetch buffer entries; also the maximum number of outstanding requests. Power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  load a new fetch PC this cycle.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word address of the request (= fetch PC).
- imem_rsp_valid  in  1  response valid; in order; no backpressure.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  decode output valid.
- if_ready  in  1  decode accepts.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  32  presented instruction.

Behaviour:
- State: pc_q, outstanding count (0..BUF_DEPTH), drop count, pending-PC FIFO (BUF_DEPTH entries), output buffer FIFO (BUF_DEPTH entries of {pc, instr}).
- Reset: pc_q=RESET_PC, all counts and FIFOs empty, if_valid=0, imem_req_valid=0. Reset has priority over every other input.
- imem_req_valid = !rst && !redirect_valid && (outstanding + buf_count < BUF_DEPTH). Registered counts only; no combinational path from if_ready or imem_rsp_valid to imem_req_valid.
- imem_req_addr = pc_q. It holds stable while valid and not accepted.
- Issue (valid && ready): push pc_q into the pending FIFO, outstanding += 1, pc_q += 4 (wraps modulo 2^XLEN).
- Response with drop count = 0: pop the pending FIFO and push {pc, rsp_data} into the output buffer. The credit rule guarantees the buffer never overflows; an overflow is an assertion failure.
- Response with drop count > 0: pop the pending FIFO, drop count -= 1, data discarded.
- Each response decrements outstanding. Issue and response in the same cycle leave outstanding unchanged.
- Output: if_valid = buffer not empty; if_pc/if_instr = head entry. Pop on if_valid && if_ready.
- Latency: the instruction appears on if_* the cycle after its response. With 1-cycle memory and if_ready held high, throughput is one instruction per cycle after a 2-cycle fill.
- Redirect (redirect_valid=1, evaluated the same cycle):
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Output buffer cleared. A pop that same cycle is ignored and if_valid=0 next cycle.
  - No request is issued that cycle.
  - drop count <= outstanding − (imem_rsp_valid ? 1 : 0); a response arriving that cycle is itself discarded.
  - Pending-FIFO entries are retained and popped by the stale responses.
- Back-to-back redirects: each recomputes drop count from the current outstanding count, so stale responses are never forwarded.
- Requests issued after a redirect may be in flight behind stale ones. In-order responses guarantee the drop count consumes exactly the stale ones first.
- Rst mid-operation: all state cleared and drop count zeroed. The memory is reset together with the core, so no responses arrive for pre-reset requests.
- Backpressure: if_ready=0 with a full buffer → imem_req_valid=0 until a pop frees credit.

Decomposition:
- Shared package `core_pkg`:
  - XLEN and the RESET_PC default.
  - INSTR_W=32 and the PC increment constant 4.
  - typedef fetch_pkt_t {pc, instr}.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/count/empty/full, synchronous clear), instantiated twice: pending-PC FIFO and output buffer.

Test Plan:
- Reset release with imem always ready, 1-cycle response, if_ready=1 → requests to 0x0, 0x4, 0x8…; if_pc 0x0 is valid at cycle 2 after the first issue, then one instruction per cycle.
- if_ready=0 for 10 cycles → exactly 4 requests issued, imem_req_valid=0 afterwards; releasing if_ready drains 0x0..0xC in order, then fetching resumes at 0x10.
- imem_req_ready=0 for 3 cycles at addr 0x8 → imem_req_addr stays 0x8 and pc_q does not advance.
- With 3 requests outstanding (0x10, 0x14, 0x18) and 3-cycle memory latency, redirect to 0x103 → next request addr 0x100; the 3 stale responses are dropped; the first if_pc after the redirect is 0x100.
- Redirect in the same cycle as a response and a pop → that response is discarded, if_valid=0 next cycle, no request that cycle.
- Redirect to 0xFFFF_FFFC → fetch sequence 0xFFFF_FFFC, then 0x0000_0000 (wrap-around).

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide constants and the fetch packet type, shared by the fetch stage and its bench.
package core_pkg;
  localparam int                XLEN     = 32;
  localparam logic [XLEN-1:0]   RESET_PC = 32'h0000_0000;
  localparam int                INSTR_W  = 32;
  localparam logic [XLEN-1:0]   PC_INC   = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage boundary: redirect input, imem request/response channel, decode handshake.
interface fetch_unit_if #(parameter int XLEN = core_pkg::XLEN);
  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_pc;
  logic                         imem_req_valid;
  logic                         imem_req_ready;
  logic [XLEN-1:0]              imem_req_addr;
  logic                         imem_rsp_valid;
  logic [core_pkg::INSTR_W-1:0] imem_rsp_data;
  logic                         if_valid;
  logic                         if_ready;
  logic [XLEN-1:0]              if_pc;
  logic [core_pkg::INSTR_W-1:0] if_instr;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle clear.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, in-order prefetch buffer, redirect with stale-response drop.
module fetch_unit #(
  parameter int              XLEN      = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
  parameter int              BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  import core_pkg::fetch_pkt_t, core_pkg::PC_INC;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pend_pc;
  logic [CW-1:0]   outstanding_q, drop_q, buf_count, pend_count;
  logic            issue, rsp, fwd, pop_out;
  logic            buf_empty, buf_full, pend_empty, pend_full;
  fetch_pkt_t      pkt_in, head;

  // Credit covers both in-flight requests and buffered results, so the buffer can never overflow.
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (({1'b0, outstanding_q} + {1'b0, buf_count}) < (CW+1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign issue   = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp     = bus.imem_rsp_valid;
  assign fwd     = rsp && (drop_q == '0) && !bus.redirect_valid;
  assign pop_out = !buf_empty && bus.if_ready && !bus.redirect_valid;
  assign pkt_in  = '{pc: pend_pc, instr: bus.imem_rsp_data};

  assign bus.if_valid = !buf_empty;
  assign bus.if_pc    = head.pc;
  assign bus.if_instr = head.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      if (bus.redirect_valid) pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)         pc_q <= pc_q + PC_INC;
      outstanding_q <= outstanding_q + CW'(issue) - CW'(rsp);
      // Everything still in flight at a redirect is stale, including a response landing this cycle.
      if (bus.redirect_valid)      drop_q <= outstanding_q - CW'(rsp);
      else if (rsp && drop_q != '0) drop_q <= drop_q - CW'(1);
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pend (
    .clk(clk), .rst(rst), .clr(1'b0),
    .push(issue), .push_data(pc_q), .pop(rsp), .pop_data(pend_pc),
    .count(pend_count), .empty(pend_empty), .full(pend_full)
  );

  sync_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(BUF_DEPTH)) u_obuf (
    .clk(clk), .rst(rst), .clr(bus.redirect_valid),
    .push(fwd), .push_data(pkt_in), .pop(pop_out), .pop_data(head),
    .count(buf_count), .empty(buf_empty), .full(buf_full)
  );

  a_buf_overflow: assert property (@(posedge clk) disable iff (rst) !(fwd && buf_full));
  a_pend_overflow: assert property (@(posedge clk) disable iff (rst) !(issue && pend_full));
  a_rsp_unexpected: assert property (@(posedge clk) disable iff (rst) !(rsp && pend_empty));
  a_pend_tracks: assert property (@(posedge clk) disable iff (rst) pend_count == outstanding_q);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model plus an epoch-tagged expected-stream scoreboard.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] mpc;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = 32'h0;
  int          epoch = 0;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // In-order memory: each accepted request answers no earlier than its due cycle.
  always @(posedge clk) begin
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-cycle reference: expected decode stream by epoch; redirects bump the epoch.
  task automatic sb_step();
    logic  red;
    mreq_t m;
    red = bus.redirect_valid;
    if (rst) begin
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL req_in_reset: got %b want 0", bus.imem_req_valid);
      end
      memq.delete(); exp_q.delete(); model_pc = RESET_PC; epoch = 0;
      return;
    end
    checks++;
    if (bus.imem_req_valid !== (!red && (memq.size() + exp_q.size() < DEPTH))) begin
      errors++; $display("FAIL credit: req_valid got %b want %b (inflight %0d buf %0d)",
                         bus.imem_req_valid, !red && (memq.size() + exp_q.size() < DEPTH), memq.size(), exp_q.size());
    end
    checks++;
    if (bus.if_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL if_valid: got %b want %b", bus.if_valid, exp_q.size() != 0);
    end
    if (bus.if_valid === 1'b1 && exp_q.size() != 0) begin
      checks++;
      if (bus.if_pc !== exp_q[0] || bus.if_instr !== mem_word(exp_q[0])) begin
        errors++; $display("FAIL out_pkt: got pc %h instr %h want pc %h instr %h",
                           bus.if_pc, bus.if_instr, exp_q[0], mem_word(exp_q[0]));
      end
      if (bus.if_ready && !red) void'(exp_q.pop_front());
    end
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
      checks++;
      if (bus.imem_req_addr !== model_pc) begin
        errors++; $display("FAIL req_addr: got %h want %h", bus.imem_req_addr, model_pc);
      end
      m.addr = bus.imem_req_addr; m.mpc = model_pc; m.epoch = epoch;
      m.due  = cyc + int'($urandom_range(lat_min, lat_max));
      memq.push_back(m);
      model_pc = model_pc + 32'd4;
    end
    if (red) begin
      epoch++; exp_q.delete(); model_pc = {bus.redirect_pc[31:2], 2'b00};
    end
    if (bus.imem_rsp_valid && memq.size() > 0) begin
      if (memq[0].epoch == epoch) exp_q.push_back(memq[0].mpc);
      void'(memq.pop_front());
    end
  endtask

  task automatic tick();   @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); sb_step(); endtask

  function automatic bit accepted();
    return bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1;
  endfunction

  task automatic do_reset();
    tick(); rst = 1'b1; sample();
    tick(); sample();
    tick(); rst = 1'b0; sample();
  endtask

  task automatic test_reset();
    tick(); sample();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_state: if_valid %b req_valid %b want 0 0", bus.if_valid, bus.imem_req_valid);
    end
    tick(); rst = 1'b0; sample();
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0 || bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: req_valid %b addr %h if_valid %b want 1 00000000 0",
                         bus.imem_req_valid, bus.imem_req_addr, bus.if_valid);
    end
  endtask

  task automatic test_fill();
    lat_min = 1; lat_max = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    do_reset();
    checks++;
    if (!accepted() || bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL fill_first_req: accepted %b addr %h want 1 00000000", accepted(), bus.imem_req_addr);
    end
    tick(); sample();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_addr !== 32'h4) begin
      errors++; $display("FAIL fill_c1: if_valid %b addr %h want 0 00000004", bus.if_valid, bus.imem_req_addr);
    end
    for (int k = 0; k < 6; k++) begin
      tick(); sample();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL fill_stream: if_valid %b pc %h want 1 %h", bus.if_valid, bus.if_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0, pops = 0;
    bit seen = 0;
    lat_min = 1; lat_max = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (accepted()) n++;
      tick(); sample();
    end
    checks++;
    if (n != 4 || bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_credit: issued %0d req_valid %b want 4 0", n, bus.imem_req_valid);
    end
    for (int i = 0; i < 12; i++) begin
      tick(); if (i == 0) bus.if_ready = 1'b1; sample();
      if (bus.if_valid === 1'b1 && pops < 8) begin
        checks++;
        if (bus.if_pc !== 32'(4 * pops)) begin
          errors++; $display("FAIL bp_drain: pc %h want %h", bus.if_pc, 32'(4 * pops));
        end
        pops++;
      end
      if (accepted() && !seen) begin
        seen = 1;
        checks++;
        if (bus.imem_req_addr !== 32'h10) begin
          errors++; $display("FAIL bp_resume: addr %h want 00000010", bus.imem_req_addr);
        end
      end
    end
    checks++;
    if (!seen || pops < 4) begin
      errors++; $display("FAIL bp_timeout: resumed %0d pops %0d want 1 >=4", seen, pops);
    end
  endtask

  task automatic test_stall();
    lat_min = 1; lat_max = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    do_reset();
    tick(); sample();
    for (int i = 0; i < 3; i++) begin
      tick(); if (i == 0) bus.imem_req_ready = 1'b0; sample();
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin
        errors++; $display("FAIL stall_hold: valid %b addr %h want 1 00000008", bus.imem_req_valid, bus.imem_req_addr);
      end
    end
    tick(); bus.imem_req_ready = 1'b1; sample();
    checks++;
    if (!accepted() || bus.imem_req_addr !== 32'h8) begin
      errors++; $display("FAIL stall_accept: accepted %b addr %h want 1 00000008", accepted(), bus.imem_req_addr);
    end
    tick(); sample();
    checks++;
    if (bus.imem_req_addr !== 32'hC) begin
      errors++; $display("FAIL stall_advance: addr %h want 0000000c", bus.imem_req_addr);
    end
  endtask

  task automatic test_redirect();
    bit found = 0, acc_seen = 0, out_seen = 0;
    lat_min = 3; lat_max = 3; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (accepted() && bus.imem_req_addr === 32'h18) begin found = 1; break; end
      tick(); sample();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL redir_setup: request 0x18 not seen, want seen"); end
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103; sample();
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL redir_no_issue: req_valid %b want 0", bus.imem_req_valid);
    end
    for (int i = 0; i < 30; i++) begin
      tick(); if (i == 0) bus.redirect_valid = 1'b0; sample();
      if (accepted() && !acc_seen) begin
        acc_seen = 1; checks++;
        if (bus.imem_req_addr !== 32'h100) begin
          errors++; $display("FAIL redir_addr: addr %h want 00000100", bus.imem_req_addr);
        end
      end
      if (bus.if_valid === 1'b1 && !out_seen) begin
        out_seen = 1; checks++;
        if (bus.if_pc !== 32'h100) begin
          errors++; $display("FAIL redir_first_out: pc %h want 00000100", bus.if_pc);
        end
      end
      if (acc_seen && out_seen) break;
    end
    checks++;
    if (!acc_seen || !out_seen) begin
      errors++; $display("FAIL redir_timeout: req %0d out %0d want 1 1", acc_seen, out_seen);
    end
  endtask

  task automatic test_redirect_collision();
    bit seen = 0;
    lat_min = 1; lat_max = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin tick(); sample(); end
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; sample();
    checks++;
    if (bus.imem_rsp_valid !== 1'b1 || bus.if_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL coll_setup: rsp %b if_valid %b req_valid %b want 1 1 0",
                         bus.imem_rsp_valid, bus.if_valid, bus.imem_req_valid);
    end
    tick(); bus.redirect_valid = 1'b0; sample();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL coll_flush: if_valid %b want 0", bus.if_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick(); sample();
      if (bus.if_valid === 1'b1) begin
        seen = 1; checks++;
        if (bus.if_pc !== 32'h200) begin
          errors++; $display("FAIL coll_first_out: pc %h want 00000200", bus.if_pc);
        end
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL coll_timeout: no output after redirect"); end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    lat_min = 1; lat_max = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE; sample();
    tick(); bus.redirect_valid = 1'b0; sample();
    checks++;
    if (!accepted() || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req0: accepted %b addr %h want 1 fffffffc", accepted(), bus.imem_req_addr);
    end
    tick(); sample();
    checks++;
    if (!accepted() || bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_req1: accepted %b addr %h want 1 00000000", accepted(), bus.imem_req_addr);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.if_valid === 1'b1) begin seen = 1; break; end
      tick(); sample();
    end
    checks++;
    if (!seen || bus.if_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_out0: seen %0d pc %h want 1 fffffffc", seen, bus.if_pc);
    end
    tick(); sample();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_out1: valid %b pc %h want 1 00000000", bus.if_valid, bus.if_pc);
    end
  endtask

  task automatic test_random();
    int pops = 0;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      bus.imem_req_ready = ($urandom_range(0, 4) != 0);
      bus.redirect_valid = ($urandom_range(0, 29) == 0);
      bus.redirect_pc    = $urandom;
      rst                = ($urandom_range(0, 299) == 0);
      sample();
      if (!rst && bus.if_valid === 1'b1 && bus.if_ready && !bus.redirect_valid) pops++;
    end
    tick(); rst = 1'b0; bus.redirect_valid = 1'b0; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1; sample();
    for (int i = 0; i < 20; i++) begin tick(); sample(); end
    checks++;
    if (pops < 100) begin errors++; $display("FAIL random_progress: pops %0d want >=100", pops); end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    sample();
    test_reset();
    test_fill();
    test_backpressure();
    test_stall();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
